// File: rtl/bcd_ascii_streamer.sv
// Serialises a packed BCD field into an ASCII byte stream, MSD first, with optional
// separators, leading-zero blanking, invalid-digit marking and a terminator byte.
module bcd_ascii_streamer #(
   parameter int         DIGITS    = 6,
   parameter int         SEP_EVERY = 2,
   parameter logic [7:0] SEP_CHAR  = 8'h3A,
   parameter bit         TERM_EN   = 1'b1,
   parameter logic [7:0] TERM_CHAR = 8'h0D,
   parameter logic [7:0] BAD_CHAR  = 8'h3F
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  blank_lz,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      SEP   = 2'd2,
      TERM  = 2'd3
   } state_t;

   state_t              state_r;
   logic [4*DIGITS-1:0] value_r;       // remaining digits, next one at the top
   logic [CW-1:0]       digit_cnt_r;   // 1-based index of the digit last loaded
   logic [CW-1:0]       grp_cnt_r;     // digits since the last separator
   logic                zrun_r;        // blanking still active

   logic [3:0]          head_nib_s;
   logic [3:0]          first_nib_s;
   logic [7:0]          next_char_s;
   logic [7:0]          first_char_s;
   logic                more_digits_s;
   logic                sep_due_s;
   logic                accept_s;

   function automatic logic [7:0] digit_char(input logic [3:0] nib,
                                             input logic       blank,
                                             input logic       last);
      if (nib > 4'd9) begin
         return BAD_CHAR;
      end else if (blank && (nib == 4'd0) && !last) begin
         return 8'h20;
      end else begin
         return 8'h30 + {4'h0, nib};
      end
   endfunction

   // Next-byte candidates and transition conditions
   always_comb begin
      head_nib_s    = value_r[4*DIGITS-1 -: 4];
      first_nib_s   = value[4*DIGITS-1 -: 4];
      next_char_s   = digit_char(head_nib_s, zrun_r, (int'(digit_cnt_r) + 1) == DIGITS);
      first_char_s  = digit_char(first_nib_s, blank_lz, DIGITS == 1);
      more_digits_s = int'(digit_cnt_r) < DIGITS;
      sep_due_s     = (SEP_EVERY != 0) && (int'(grp_cnt_r) == SEP_EVERY);
      accept_s      = out_valid && out_ready;
   end

   // Frame FSM with registered stream outputs
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_r     <= IDLE;
         value_r     <= '0;
         digit_cnt_r <= '0;
         grp_cnt_r   <= '0;
         zrun_r      <= 1'b0;
         out_data    <= 8'h00;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  value_r     <= value << 3'd4;
                  zrun_r      <= blank_lz && (first_nib_s == 4'd0);
                  digit_cnt_r <= CW'(1'b1);
                  grp_cnt_r   <= CW'(1'b1);
                  out_data    <= first_char_s;
                  out_valid   <= 1'b1;
                  busy        <= 1'b1;
                  state_r     <= DIGIT;
               end
            end
            DIGIT: begin
               if (accept_s) begin
                  if (more_digits_s && sep_due_s) begin
                     out_data  <= SEP_CHAR;
                     grp_cnt_r <= '0;
                     state_r   <= SEP;
                  end else if (more_digits_s) begin
                     out_data    <= next_char_s;
                     value_r     <= value_r << 3'd4;
                     digit_cnt_r <= digit_cnt_r + CW'(1'b1);
                     grp_cnt_r   <= grp_cnt_r + CW'(1'b1);
                     zrun_r      <= zrun_r && (head_nib_s == 4'd0);
                  end else if (TERM_EN) begin
                     out_data <= TERM_CHAR;
                     state_r  <= TERM;
                  end else begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state_r   <= IDLE;
                  end
               end
            end
            SEP: begin
               if (accept_s) begin
                  out_data    <= next_char_s;
                  value_r     <= value_r << 3'd4;
                  digit_cnt_r <= digit_cnt_r + CW'(1'b1);
                  grp_cnt_r   <= grp_cnt_r + CW'(1'b1);
                  zrun_r      <= zrun_r && (head_nib_s == 4'd0);
                  state_r     <= DIGIT;
               end
            end
            TERM: begin
               if (accept_s) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Self-checking bench for bcd_ascii_streamer: vector table plus scoreboard of expected bytes,
// with hand-written sequences for restart, mid-frame start, reset abort and an 8-digit variant.
module tb_bcd_ascii_streamer;

   logic        clk = 1'b0;
   logic        reset_p = 1'b1;
   logic        start = 1'b0;
   logic [23:0] value = 24'h0;
   logic        blank_lz = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;

   logic        start8 = 1'b0;
   logic [31:0] value8 = 32'h0;
   logic        blank8 = 1'b0;
   logic [7:0]  out_data8;
   logic        out_valid8;
   logic        ready8 = 1'b1;
   logic        busy8;
   logic        done8;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic       prev_rst   = 1'b1;
   logic       prev_done  = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   typedef struct {
      logic [23:0] v;
      logic        b;
      logic [71:0] exp;
      bit          rnd;
   } vec_t;

   vec_t vecs[10];

   bcd_ascii_streamer u_dut (
      .clk(clk), .reset_p(reset_p), .start(start), .value(value), .blank_lz(blank_lz),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   bcd_ascii_streamer #(.DIGITS(8), .SEP_EVERY(0), .TERM_EN(1'b0)) u_dut8 (
      .clk(clk), .reset_p(reset_p), .start(start8), .value(value8), .blank_lz(blank8),
      .out_data(out_data8), .out_valid(out_valid8), .out_ready(ready8), .busy(busy8), .done(done8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expected byte per transfer, checks hold and done width
   always @(negedge clk) begin
      logic [7:0] e;
      if (prev_valid && !prev_ready && !prev_rst) begin
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid === 1'b1 && out_ready && !reset_p) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_byte: got %0h expected no byte at %0t", out_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("byte", {24'd0, out_data}, {24'd0, e});
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      end
      prev_valid = (out_valid === 1'b1);
      prev_ready = out_ready;
      prev_rst   = reset_p;
      prev_done  = (done === 1'b1);
      prev_data  = out_data;
   end

   task automatic start_frame(input logic [23:0] v, input logic b, input logic [71:0] exp);
      for (int i = 8; i >= 0; i--) exp_q.push_back(exp[8*i +: 8]);
      @(posedge clk); #1;
      value = v; blank_lz = b; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      value = 24'($urandom);
      blank_lz = ~b;
   endtask

   // Caller sits at a negedge; counts negedges until done or budget expiry
   task automatic wait_done(input bit rnd, input int c0, output int cyc);
      cyc = c0;
      while (done !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("valid_at_done", {31'd0, out_valid}, 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_frame(input logic [23:0] v, input logic b, input logic [71:0] exp, input bit rnd);
      int cyc;
      start_frame(v, b, exp);
      @(negedge clk);
      check("first_valid", {31'd0, out_valid}, 32'd1);
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      wait_done(rnd, 1, cyc);
      if (!rnd) check("frame_cycles", 32'(cyc), 32'd10);
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int d0;
      logic [63:0] exp8;

      vecs[0] = '{24'h123456, 1'b0, {"12:34:56", 8'h0D}, 1'b0};
      vecs[1] = '{24'h000905, 1'b1, {"  : 9:05", 8'h0D}, 1'b0};
      vecs[2] = '{24'h000000, 1'b1, {"  :  : 0", 8'h0D}, 1'b0};
      vecs[3] = '{24'h12A456, 1'b0, {"12:?4:56", 8'h0D}, 1'b0};
      vecs[4] = '{24'h000000, 1'b0, {"00:00:00", 8'h0D}, 1'b0};
      vecs[5] = '{24'h0F0001, 1'b1, {" ?:00:01", 8'h0D}, 1'b0};
      vecs[6] = '{24'h987650, 1'b1, {"98:76:50", 8'h0D}, 1'b0};
      vecs[7] = '{24'hFFFFFF, 1'b0, {"??:??:??", 8'h0D}, 1'b0};
      vecs[8] = '{24'h123456, 1'b0, {"12:34:56", 8'h0D}, 1'b1};
      vecs[9] = '{24'h000905, 1'b1, {"  : 9:05", 8'h0D}, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      #1 reset_p = 1'b0;

      foreach (vecs[i]) run_frame(vecs[i].v, vecs[i].b, vecs[i].exp, vecs[i].rnd);

      // start re-pulsed mid-frame must be ignored
      start_frame(24'h123456, 1'b0, {"12:34:56", 8'h0D});
      @(posedge clk); #1;
      start = 1'b1; value = 24'h999999; blank_lz = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      wait_done(1'b0, 3, cyc);
      check("midstart_cycles", 32'(cyc), 32'd10);

      // new start in the done cycle begins the next frame immediately
      for (int i = 8; i >= 0; i--) exp_q.push_back(vecs[3].exp[8*i +: 8]);
      value = vecs[3].v; blank_lz = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("restart_valid", {31'd0, out_valid}, 32'd1);
      check("restart_busy", {31'd0, busy}, 32'd1);
      wait_done(1'b0, 1, cyc);
      check("restart_cycles", 32'(cyc), 32'd10);

      // reset while byte 4 is on the bus aborts without done
      start_frame(24'h123456, 1'b0, {"12:34:56", 8'h0D});
      repeat (3) @(posedge clk);
      #1 reset_p = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      reset_p = 1'b0; out_ready = 1'b1;
      d0 = done_cnt;
      exp_q.delete();
      @(negedge clk);
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (5) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'(d0));
      run_frame(24'h123456, 1'b0, {"12:34:56", 8'h0D}, 1'b0);

      // 8 digits, no separators, no terminator
      exp8 = "20240817";
      @(posedge clk); #1;
      value8 = 32'h20240817; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; value8 = 32'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("d8_valid", {31'd0, out_valid8}, 32'd1);
         check("d8_byte", {24'd0, out_data8}, {24'd0, exp8[8*(7-i) +: 8]});
      end
      @(negedge clk);
      check("d8_done", {31'd0, done8}, 32'd1);
      check("d8_valid_end", {31'd0, out_valid8}, 32'd0);
      check("d8_busy_end", {31'd0, busy8}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
